// File: rtl/ripple_wide_add_seq.sv
// Wide W = M*N bit adder that reuses one M-bit ripple adder, one word per cycle, LSW first.
// Define SUB_EN to add the sub_i port and the A-B mode (B inverted, initial carry forced to 1).

module ripple_adder #(
    parameter int M = 4
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    input  logic         cin_i,
    output logic [M-1:0] sum_o,
    output logic         cout_o
);
    logic carry;

    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < M; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end
endmodule

module ripple_wide_add_seq #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [M*N-1:0] a_i,
    input  logic [M*N-1:0] b_i,
    input  logic           cin_i,
`ifdef SUB_EN
    input  logic           sub_i,
`endif
    output logic           ready_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [M*N-1:0] sum_o,
    output logic           cout_o
);
    localparam int W  = M * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            done_q;
    logic            busy_q;
    logic            ready_q;
    logic            sub_q;

    logic [M-1:0]    a_word;
    logic [M-1:0]    b_word;
    logic [M-1:0]    add_sum;
    logic            add_cout;

`ifndef SUB_EN
    assign sub_q = 1'b0;
`endif

    // Word select uses constant slices so N=1 never produces an out-of-range index.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                a_word = a_q[i*M +: M];
                b_word = b_q[i*M +: M];
            end
        end
        if (sub_q) begin
            b_word = ~b_word;
        end
    end

    ripple_adder #(.M(M)) u_adder (
        .a_i    (a_word),
        .b_i    (b_word),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        cnt_q   <= '0;
`ifdef SUB_EN
                        sub_q   <= sub_i;
                        carry_q <= sub_i ? 1'b1 : cin_i;
`else
                        carry_q <= cin_i;
`endif
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt_q == CW'(i)) begin
                            sum_q[i*M +: M] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q  <= add_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
endmodule
